// File: rtl/linear_transform_pkg.sv
// Shared constants and types for the linear-transform coefficient loader.
// Holds the table depth, the word-address map of the configuration port,
// the error-flag bit positions and the loader state encoding.
package linear_transform_pkg;

    // Segments per table; the address map below assumes a power of two.
    localparam int TBL_DEPTH = 16;
    localparam int IDX_W     = $clog2(TBL_DEPTH);

    // Word-address region bases on cfg_addr.
    localparam logic [5:0] ADDR_M_BASE   = 6'd0;
    localparam logic [5:0] ADDR_C_BASE   = 6'd16;
    localparam logic [5:0] ADDR_D_BASE   = 6'd32;
    localparam logic [5:0] ADDR_INV_BASE = 6'd48;

    // Bit positions inside err_flags.
    localparam int ERR_ORDER = 0;
    localparam int ERR_BUSY  = 1;
    localparam int ERR_ADDR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ARMED = 2'd2,
        ST_COPY  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/coef_order_checker.sv
// Ascending-order scan over the shadow breakpoint table.
// While en_i is high it walks one adjacent pair (M[k], M[k+1]) per cycle,
// starting at k=0 on the first enabled cycle; en_i low rewinds the scan.
// Ports:
//   clock, rst_n  - clock, asynchronous active-low reset
//   en_i          - scan active (loader is in CHECK)
//   m_i           - shadow breakpoints, segment k at [k*DSIZE +: DSIZE]
//   pair_fail_o   - current pair is not strictly ascending
//   last_pair_o   - current pair is the final one (k = depth-2)
module coef_order_checker
    import linear_transform_pkg::*;
#(
    parameter int DSIZE = 12
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic [TBL_DEPTH*DSIZE-1:0] m_i,
    output logic                       pair_fail_o,
    output logic                       last_pair_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DSIZE-1:0] m_lo, m_hi;

    always_comb begin
        idx_d = en_i ? idx_q + 1'b1 : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
    end

    always_comb begin
        m_lo        = m_i[int'(idx_q) * DSIZE +: DSIZE];
        m_hi        = m_i[(int'(idx_q) + 1) * DSIZE +: DSIZE];
        pair_fail_o = en_i && !(m_lo < m_hi);
        last_pair_o = (idx_q == IDX_W'(TBL_DEPTH - 2));
    end

endmodule

// File: rtl/linear_transform_coef_loader.sv
// Coefficient loader for a 16-segment piecewise-linear transform.
// Software fills a shadow table (breakpoints M, segment bases C, slopes delta)
// one word per cycle, then requests a commit. The loader checks that M is
// strictly ascending, waits for the next vsync rising edge and copies the
// whole shadow table into the active table in one edge, so the downstream
// stage never sees a half-updated table inside a frame.
// Ports:
//   clock, rst_n          - clock, asynchronous active-low reset
//   cfg_wr/addr/wdata     - shadow write port (0-15 M, 16-31 C, 32-47 delta)
//   commit_req            - request shadow-to-active transfer
//   vsync                 - frame sync; commit lands on its rising edge
//   err_clr               - clears the sticky error flags
//   cfg_busy              - loader not idle
//   commit_done           - one-cycle pulse after the active table changed
//   err_flags             - {bad address, access while busy, M not ascending}
//   m_bus, c_bus, d_bus   - active table, segment k at [k*W +: W]
module linear_transform_coef_loader
    import linear_transform_pkg::*;
#(
    parameter int DSIZE = 12,
    parameter int DT_I  = 8,
    parameter int DT_D  = 4
) (
    input  logic                                clock,
    input  logic                                rst_n,
    input  logic                                cfg_wr,
    input  logic [5:0]                          cfg_addr,
    input  logic [15:0]                         cfg_wdata,
    input  logic                                commit_req,
    input  logic                                vsync,
    input  logic                                err_clr,
    output logic                                cfg_busy,
    output logic                                commit_done,
    output logic [2:0]                          err_flags,
    output logic [TBL_DEPTH*DSIZE-1:0]          m_bus,
    output logic [TBL_DEPTH*DSIZE-1:0]          c_bus,
    output logic [TBL_DEPTH*(DT_I+DT_D)-1:0]    d_bus
);

    localparam int DW = DT_I + DT_D;
    localparam logic [DW-1:0] D_UNITY = DW'(1) << DT_D;

    // Identity breakpoint / base for segment k: evenly spaced over the range.
    function automatic logic [DSIZE-1:0] ident_bp(input int k);
        return DSIZE'(k * (2 ** (DSIZE - 4)));
    endfunction

    cfg_state_e       state_q, state_d;
    logic             vsync_q;
    logic [2:0]       err_q, err_d, err_set;
    logic             commit_done_q, commit_done_d;

    logic [DSIZE-1:0] sh_m_q  [TBL_DEPTH];
    logic [DSIZE-1:0] sh_c_q  [TBL_DEPTH];
    logic [DW-1:0]    sh_d_q  [TBL_DEPTH];
    logic [DSIZE-1:0] act_m_q [TBL_DEPTH];
    logic [DSIZE-1:0] act_c_q [TBL_DEPTH];
    logic [DW-1:0]    act_d_q [TBL_DEPTH];

    logic [TBL_DEPTH*DSIZE-1:0] sh_m_flat;
    logic                       chk_en, pair_fail, last_pair;

    // ---------------------------------------------------------------------
    // Write decode: only IDLE accepts writes; regions are 16-word aligned so
    // the low address bits index the segment directly.
    // ---------------------------------------------------------------------
    logic             idle, wr_ok, wr_m, wr_c, wr_d;
    logic [IDX_W-1:0] wr_idx;

    always_comb begin
        idle   = (state_q == ST_IDLE);
        wr_ok  = cfg_wr && idle;
        wr_m   = wr_ok && (cfg_addr >= ADDR_M_BASE) && (cfg_addr < ADDR_C_BASE);
        wr_c   = wr_ok && (cfg_addr >= ADDR_C_BASE) && (cfg_addr < ADDR_D_BASE);
        wr_d   = wr_ok && (cfg_addr >= ADDR_D_BASE) && (cfg_addr < ADDR_INV_BASE);
        wr_idx = cfg_addr[IDX_W-1:0];
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        err_set       = '0;
        commit_done_d = 1'b0;
        chk_en        = (state_q == ST_CHECK);

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_wr && (cfg_addr >= ADDR_INV_BASE)) err_set[ERR_ADDR] = 1'b1;
                if (commit_req) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (pair_fail) begin
                    err_set[ERR_ORDER] = 1'b1;
                    state_d            = ST_IDLE;
                end else if (last_pair) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Edge qualified only here, so an edge seen during CHECK is lost.
                if (vsync && !vsync_q) state_d = ST_COPY;
            end
            ST_COPY: begin
                commit_done_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!idle && (cfg_wr || commit_req)) err_set[ERR_BUSY] = 1'b1;

        // A set in the same cycle as a clear wins.
        err_d = (err_clr ? 3'b000 : err_q) | err_set;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b0;
            err_q         <= '0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync;
            err_q         <= err_d;
            commit_done_q <= commit_done_d;
        end
    end

    // ---------------------------------------------------------------------
    // Shadow and active tables
    // ---------------------------------------------------------------------
    // NOTE: these tables are plain flops, not RAM, so resetting them is legal
    // and required: both come out of reset holding the identity transform.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TBL_DEPTH; k++) begin
                sh_m_q[k] <= ident_bp(k);
                sh_c_q[k] <= ident_bp(k);
                sh_d_q[k] <= D_UNITY;
            end
        end else begin
            if (wr_m) sh_m_q[wr_idx] <= DSIZE'(cfg_wdata);
            if (wr_c) sh_c_q[wr_idx] <= DSIZE'(cfg_wdata);
            if (wr_d) sh_d_q[wr_idx] <= DW'(cfg_wdata);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TBL_DEPTH; k++) begin
                act_m_q[k] <= ident_bp(k);
                act_c_q[k] <= ident_bp(k);
                act_d_q[k] <= D_UNITY;
            end
        end else if (state_q == ST_COPY) begin
            for (int k = 0; k < TBL_DEPTH; k++) begin
                act_m_q[k] <= sh_m_q[k];
                act_c_q[k] <= sh_c_q[k];
                act_d_q[k] <= sh_d_q[k];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Order check and output packing
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < TBL_DEPTH; g++) begin : g_pack
        assign sh_m_flat[g*DSIZE +: DSIZE] = sh_m_q[g];
        assign m_bus[g*DSIZE +: DSIZE]     = act_m_q[g];
        assign c_bus[g*DSIZE +: DSIZE]     = act_c_q[g];
        assign d_bus[g*DW +: DW]           = act_d_q[g];
    end

    coef_order_checker #(
        .DSIZE (DSIZE)
    ) u_order_checker (
        .clock       (clock),
        .rst_n       (rst_n),
        .en_i        (chk_en),
        .m_i         (sh_m_flat),
        .pair_fail_o (pair_fail),
        .last_pair_o (last_pair)
    );

    assign cfg_busy    = !idle;
    assign commit_done = commit_done_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_linear_transform_coef_loader.sv
// Directed bench for linear_transform_coef_loader. DSIZE is set to 10 so the
// identity breakpoint step is 2^(10-4) = 64 (segment 3 = 192, 5 = 320,
// 6 = 384). A small shadow/active model holds the expected tables.
module tb_linear_transform_coef_loader;

    localparam int DSIZE = 10;
    localparam int DT_I  = 8;
    localparam int DT_D  = 4;
    localparam int DW    = DT_I + DT_D;
    localparam int N     = 16;

    logic                clock = 1'b0;
    logic                rst_n;
    logic                cfg_wr;
    logic [5:0]          cfg_addr;
    logic [15:0]         cfg_wdata;
    logic                commit_req;
    logic                vsync;
    logic                err_clr;
    logic                cfg_busy;
    logic                commit_done;
    logic [2:0]          err_flags;
    logic [N*DSIZE-1:0]  m_bus;
    logic [N*DSIZE-1:0]  c_bus;
    logic [N*DW-1:0]     d_bus;

    int n_vec  = 0;
    int n_miss = 0;

    logic [DSIZE-1:0] sh_m [N], sh_c [N], act_m [N], act_c [N];
    logic [DW-1:0]    sh_d [N], act_d [N];

    always #5 clock = ~clock;

    linear_transform_coef_loader #(
        .DSIZE (DSIZE),
        .DT_I  (DT_I),
        .DT_D  (DT_D)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .commit_req  (commit_req),
        .vsync       (vsync),
        .err_clr     (err_clr),
        .cfg_busy    (cfg_busy),
        .commit_done (commit_done),
        .err_flags   (err_flags),
        .m_bus       (m_bus),
        .c_bus       (c_bus),
        .d_bus       (d_bus)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            sh_m[k]  = DSIZE'(k * 64);
            sh_c[k]  = DSIZE'(k * 64);
            sh_d[k]  = DW'(16);
            act_m[k] = sh_m[k];
            act_c[k] = sh_c[k];
            act_d[k] = sh_d[k];
        end
    endfunction

    function automatic void model_commit();
        for (int k = 0; k < N; k++) begin
            act_m[k] = sh_m[k];
            act_c[k] = sh_c[k];
            act_d[k] = sh_d[k];
        end
    endfunction

    function automatic logic [N*DSIZE-1:0] exp_m_bus();
        logic [N*DSIZE-1:0] v;
        for (int k = 0; k < N; k++) v[k*DSIZE +: DSIZE] = act_m[k];
        return v;
    endfunction

    function automatic logic [N*DSIZE-1:0] exp_c_bus();
        logic [N*DSIZE-1:0] v;
        for (int k = 0; k < N; k++) v[k*DSIZE +: DSIZE] = act_c[k];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_d_bus();
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = act_d[k];
        return v;
    endfunction

    function automatic logic [DSIZE-1:0] mseg(input int k);
        return m_bus[k*DSIZE +: DSIZE];
    endfunction

    function automatic logic [DSIZE-1:0] cseg(input int k);
        return c_bus[k*DSIZE +: DSIZE];
    endfunction

    function automatic logic [DW-1:0] dseg(input int k);
        return d_bus[k*DW +: DW];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [15:0] data);
        cfg_wr    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic check_tables(input string tag);
        check({tag, " m_bus"}, m_bus, exp_m_bus());
        check({tag, " c_bus"}, c_bus, exp_c_bus());
        check({tag, " d_bus"}, d_bus, exp_d_bus());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cycles;
        bit  seen_done;
        bit  busy_low;
        bit  seg_moved;

        rst_n      = 1'b0;
        cfg_wr     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        commit_req = 1'b0;
        vsync      = 1'b0;
        err_clr    = 1'b0;
        model_reset();

        // ---- reset state ----
        #12;
        check("rst busy", cfg_busy, 0);
        check("rst done", commit_done, 0);
        check("rst err", err_flags, 0);
        #10 rst_n = 1'b1;
        tick();
        check("rst m5", mseg(5), 320);
        check("rst c5", cseg(5), 320);
        check("rst d5", dseg(5), 16);
        check_tables("rst");

        // ---- invalid address: flag only, shadow untouched ----
        wr(6'd50, 16'h0123);
        check("badaddr err", err_flags, 3'b100);
        check("badaddr busy", cfg_busy, 0);
        clear_err();
        check("errclr", err_flags, 3'b000);
        // Clear and a new set in the same cycle: the set survives.
        err_clr = 1'b1;
        wr(6'd63, 16'h0001);
        err_clr = 1'b0;
        check("clr vs set", err_flags, 3'b100);
        clear_err();

        // ---- descending M: check fails at pair (6,7) ----
        wr(6'd7, 16'd100);
        sh_m[7] = 10'd100;
        commit();
        check("bad busy", cfg_busy, 1);
        cycles = 0;
        while (cfg_busy && cycles < 20) begin
            tick();
            cycles++;
        end
        check("bad check cycles", cycles, 7);
        check("bad err", err_flags, 3'b001);
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (commit_done) seen_done = 1;
            tick();
        end
        check("bad no commit", seen_done, 0);
        check_tables("bad");
        clear_err();

        // ---- valid commit with M[3]=500 ----
        // Upper breakpoints are raised first; M[3]=500 alone would sit above
        // the identity M[4]=256 and fail the order check.
        for (int k = 4; k < N; k++) begin
            wr(6'(k), 16'(520 + (k - 4) * 40));
            sh_m[k] = DSIZE'(520 + (k - 4) * 40);
        end
        wr(6'd3, 16'd500);
        sh_m[3] = 10'd500;
        commit();
        busy_low  = 0;
        seg_moved = 0;
        for (int i = 0; i < 55; i++) begin     // 15 check cycles + 40 wait
            if (!cfg_busy) busy_low = 1;
            if (mseg(3) != 10'd192) seg_moved = 1;
            tick();
        end
        check("ok busy held", busy_low, 0);
        check("ok m3 held", seg_moved, 0);
        check("ok err", err_flags, 0);
        vsync = 1'b1;
        tick();
        check("ok m3 at edge", mseg(3), 192);
        check("ok done at edge", commit_done, 0);
        tick();
        vsync = 1'b0;
        model_commit();
        check("ok m3 after", mseg(3), 500);
        check("ok done pulse", commit_done, 1);
        check("ok busy after", cfg_busy, 0);
        check_tables("ok");
        tick();
        check("ok done drop", commit_done, 0);

        // ---- vsync high through CHECK: needs a fresh edge ----
        wr(6'd18, 16'd777);
        sh_c[2] = 10'd777;
        wr(6'd32, 16'h0028);
        sh_d[0] = 12'h028;
        vsync = 1'b1;
        tick();
        commit();
        seen_done = 0;
        for (int i = 0; i < 25; i++) begin
            if (commit_done) seen_done = 1;
            tick();
        end
        check("vhold no commit", seen_done, 0);
        check("vhold busy", cfg_busy, 1);
        check("vhold c2", cseg(2), 128);
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        tick();
        model_commit();
        check("vhold done", commit_done, 1);
        check("vhold c2 after", cseg(2), 777);
        check("vhold d0 after", dseg(0), 12'h028);
        vsync = 1'b0;
        tick();

        // ---- write and commit_req while ARMED are dropped ----
        commit();
        for (int i = 0; i < 15; i++) tick();
        check("armed busy", cfg_busy, 1);
        check("armed err0", err_flags, 0);
        cfg_wr     = 1'b1;
        cfg_addr   = 6'd5;
        cfg_wdata  = 16'd0;
        commit_req = 1'b1;
        tick();
        cfg_wr     = 1'b0;
        commit_req = 1'b0;
        check("armed wr err", err_flags, 3'b010);
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        model_commit();
        check("armed done", commit_done, 1);
        check("armed m5 kept", mseg(5), 560);
        check_tables("armed");
        clear_err();

        // ---- reset while ARMED discards the pending commit ----
        wr(6'd2, 16'd300);
        sh_m[2] = 10'd300;
        commit();
        for (int i = 0; i < 15; i++) tick();
        check("prerst busy", cfg_busy, 1);
        rst_n = 1'b0;
        #2;
        check("midrst busy", cfg_busy, 0);
        model_reset();
        rst_n = 1'b1;
        tick();
        check("postrst m3", mseg(3), 192);
        check("postrst err", err_flags, 0);
        check_tables("postrst");
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (commit_done) seen_done = 1;
            tick();
        end
        check("postrst no commit", seen_done, 0);
        check("postrst m2", mseg(2), 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/linear_transform_coef_loader.md
LINEAR_TRANSFORM_COEF_LOADER -- requirements
Module: linear_transform_coef_loader

Interface
REQ-001 SHALL have parameter DSIZE, default 12: pixel and breakpoint width, shared with the downstream piecewise-linear stage.
REQ-002 SHALL have parameter DT_I, default 8: integer bits of the slope coefficient.
REQ-003 SHALL have parameter DT_D, default 4: fractional bits of the slope coefficient.
REQ-004 SHALL have port clock  in  1  single clock; all logic rises on it.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port cfg_wr  in  1  shadow-table write strobe, one word per cycle.
REQ-007 SHALL have port cfg_addr  in  6  word address: 0-15 M (breakpoint), 16-31 C (segment base), 32-47 delta (slope), 48-63 invalid.
REQ-008 SHALL have port cfg_wdata  in  16  write data, LSB-aligned, truncated to target width.
REQ-009 SHALL have port commit_req  in  1  pulse requesting shadow-to-active transfer.
REQ-010 SHALL have port vsync  in  1  frame sync; active table changes only on its rising edge.
REQ-011 SHALL have port err_clr  in  1  clears err_flags.
REQ-012 SHALL have port cfg_busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port commit_done  out  1  one-cycle pulse after the active table is updated.
REQ-014 SHALL have port err_flags  out  3  sticky: bit0 M not ascending, bit1 write or commit while busy, bit2 invalid address.
REQ-015 SHALL have port m_bus  out  16*DSIZE  active M; segment k at [k*DSIZE +: DSIZE].
REQ-016 SHALL have port c_bus  out  16*DSIZE  active C, same packing.
REQ-017 SHALL have port d_bus  out  16*(DT_I+DT_D)  active delta, same packing.

Function
REQ-018 SHALL hold a shadow table (written by cfg_wr) and an active table (driving the buses); the buses SHALL be registers driven only by the active table.
REQ-019 SHALL implement states IDLE, CHECK, ARMED, COPY.
REQ-020 SHALL, in IDLE, accept cfg_wr to addresses 0-47 and update the shadow word on the same edge.
REQ-021 SHALL ignore writes to addresses 48-63, leave the shadow unchanged and set err_flags[2].
REQ-022 SHALL, in IDLE, move to CHECK on commit_req; a cfg_wr in the same cycle SHALL land first and be covered by the check.
REQ-023 SHALL, in CHECK, compare shadow M[k] < M[k+1] for k=0..14, one pair per cycle (15 cycles).
REQ-024 SHALL, on any failing pair, set err_flags[0], return to IDLE and leave the active table unchanged.
REQ-025 SHALL, on all pairs passing, enter ARMED and wait indefinitely for a vsync rising edge (vsync=1 with the registered previous value 0).
REQ-026 SHALL go from ARMED to COPY on that edge, copy all 48 words in a single edge, assert commit_done for exactly the following cycle, and return to IDLE.
REQ-027 SHALL, whenever state is not IDLE, drop cfg_wr and commit_req and set err_flags[1].
REQ-028 SHALL hold err_flags bits until err_clr; a set event in the same cycle as err_clr SHALL win.
REQ-029 SHALL detect the vsync edge only in ARMED; an edge arriving during CHECK SHALL NOT cause a commit.

Reset
REQ-030 SHALL, on rst_n low, force state IDLE, cfg_busy 0, commit_done 0, err_flags 0, and vsync history 0.
REQ-031 SHALL reset both tables to identity: M[k]=C[k]=k*2^(DSIZE-4), delta[k]=2^DT_D (slope 1.0).
REQ-032 SHALL, when reset occurs mid-CHECK or ARMED, discard the pending commit and keep no partial state.

Structure
REQ-033 SHALL take the table depth (16), address-region bases (0/16/32/48), and the state encoding from a shared package linear_transform_pkg.
REQ-034 SHALL place the ascending-order scan in one sub-module, coef_order_checker.

Verification
REQ-035 SHALL show that after reset, with no writes, m_bus segment 5 = 320, c_bus segment 5 = 320, and d_bus segment 5 = 16.
REQ-036 SHALL show that writing M[3]=500, then commit_req, then vsync rising 40 cycles later gives cfg_busy for 15 check cycles plus the wait; m_bus segment 3 stays 192 until the vsync edge, is 500 on the next edge, and commit_done pulses once.
REQ-037 SHALL show that writing M[7]=100 (below M[6]=384), then commit_req, sets err_flags=3'b001, returns to IDLE after the check, and a later vsync leaves the active table unchanged.
REQ-038 SHALL show that a cfg_wr to address 50 sets err_flags[2] with no shadow change, and that a cfg_wr during ARMED sets err_flags[1] with no shadow change.
REQ-039 SHALL show that vsync held high throughout CHECK produces no commit until vsync falls and rises again.
REQ-040 SHALL show that rst_n asserted during ARMED returns the tables to identity, and a subsequent vsync produces no commit_done.
